// File: rtl/controle_elevador_pkg.sv
// Shared definitions for the three-floor elevator controller:
// state encoding, floor codes, timing defaults and call-vector helpers.
package controle_elevador_pkg;

  typedef enum logic [1:0] {
    PARADO       = 2'b00,
    SUBINDO      = 2'b01,
    DESCENDO     = 2'b10,
    PORTA_ABERTA = 2'b11
  } estado_t;

  typedef enum logic {
    DIR_DESCE = 1'b0,
    DIR_SOBE  = 1'b1
  } dir_t;

  localparam logic [1:0] ANDAR_T = 2'b00;
  localparam logic [1:0] ANDAR_P = 2'b01;
  localparam logic [1:0] ANDAR_S = 2'b10;

  localparam int T_VIAGEM_PAD = 8;
  localparam int T_PORTA_PAD  = 6;
  localparam int CNT_W        = 8;

  // Call vectors are ordered {S, P, T}; bit 0 is the ground floor.
  function automatic logic [2:0] decodifica_andar(input logic [1:0] andar);
    logic [2:0] r;
    case (andar)
      ANDAR_T: r = 3'b001;
      ANDAR_P: r = 3'b010;
      ANDAR_S: r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Floors strictly above the given one.
  function automatic logic [2:0] mascara_acima(input logic [1:0] andar);
    logic [2:0] r;
    case (andar)
      ANDAR_T: r = 3'b110;
      ANDAR_P: r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Floors strictly below the given one.
  function automatic logic [2:0] mascara_abaixo(input logic [1:0] andar);
    logic [2:0] r;
    case (andar)
      ANDAR_S: r = 3'b011;
      ANDAR_P: r = 3'b001;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/controle_elevador_temporizador.sv
// Loadable down-counter; fim_o is high while the count sits at zero.
// A load of N-1 therefore gives exactly N enabled cycles before fim_o.
module controle_elevador_temporizador
  import controle_elevador_pkg::*;
#(
  parameter int LARGURA = CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               carga_i,
  input  logic [LARGURA-1:0] valor_i,
  input  logic               en_i,
  output logic               fim_o
);

  localparam logic [LARGURA-1:0] ZERO = {LARGURA{1'b0}};
  localparam logic [LARGURA-1:0] UM   = {{(LARGURA-1){1'b0}}, 1'b1};

  logic [LARGURA-1:0] cont_q;
  logic [LARGURA-1:0] cont_d;

  // Next count: load wins, otherwise count down while enabled and not at zero.
  always_comb begin
    cont_d = cont_q;
    if (carga_i) begin
      cont_d = valor_i;
    end else if (en_i && (cont_q != ZERO)) begin
      cont_d = cont_q - UM;
    end else begin
      cont_d = cont_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cont_q <= ZERO;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign fim_o = (cont_q == ZERO);

endmodule

// File: rtl/controle_elevador.sv
// Three-floor elevator controller: serves level calls CT/CP/CS, keeps the
// last travel direction to break ties, and pulses a one-cycle acknowledge
// when the door opens (or reopens) at the called floor.
module controle_elevador
  import controle_elevador_pkg::*;
#(
  parameter int T_VIAGEM = T_VIAGEM_PAD,
  parameter int T_PORTA  = T_PORTA_PAD
) (
  input  logic CLK,
  input  logic RST,
  input  logic CT,
  input  logic CP,
  input  logic CS,
  output logic A1,
  output logic A0,
  output logic SUBIR,
  output logic DESCER,
  output logic PORTA,
  output logic LT,
  output logic LP,
  output logic LS
);

  localparam logic [CNT_W-1:0] CARGA_VIAGEM = CNT_W'(T_VIAGEM - 1);
  localparam logic [CNT_W-1:0] CARGA_PORTA  = CNT_W'(T_PORTA - 1);

  estado_t    estado_q, estado_d;
  logic [1:0] andar_q, andar_d;
  dir_t       dir_q, dir_d;
  logic       subir_q, subir_d;
  logic       descer_q, descer_d;
  logic       porta_q, porta_d;
  logic [2:0] ack_q, ack_d;

  logic       carga_viagem_s, carga_porta_s, ack_ev_s;
  logic       fim_viagem_s, fim_porta_s;
  logic [2:0] chamadas_s;
  logic [1:0] andar_sobe_s, andar_desce_s;
  logic       aqui_s, acima_s, abaixo_s, ack_ativo_s;
  logic       sobe_aqui_s, sobe_acima_s, desce_aqui_s, desce_abaixo_s;

  assign chamadas_s    = {CS, CP, CT};
  assign andar_sobe_s  = (andar_q == ANDAR_S) ? andar_q : andar_q + 2'd1;
  assign andar_desce_s = (andar_q == ANDAR_T) ? andar_q : andar_q - 2'd1;

  assign aqui_s   = |(chamadas_s & decodifica_andar(andar_q));
  assign acima_s  = |(chamadas_s & mascara_acima(andar_q));
  assign abaixo_s = |(chamadas_s & mascara_abaixo(andar_q));

  // Decisions taken on the arrival cycle look at the floor being reached.
  assign sobe_aqui_s    = |(chamadas_s & decodifica_andar(andar_sobe_s));
  assign sobe_acima_s   = |(chamadas_s & mascara_acima(andar_sobe_s));
  assign desce_aqui_s   = |(chamadas_s & decodifica_andar(andar_desce_s));
  assign desce_abaixo_s = |(chamadas_s & mascara_abaixo(andar_desce_s));

  // While the acknowledge is out the selector has not cleared the call yet,
  // so a still-high call must not be taken as a fresh door request.
  assign ack_ativo_s = |(ack_q & decodifica_andar(andar_q));

  controle_elevador_temporizador #(.LARGURA(CNT_W)) u_temp_viagem (
    .clk     (CLK),
    .rst     (RST),
    .carga_i (carga_viagem_s),
    .valor_i (CARGA_VIAGEM),
    .en_i    ((estado_q == SUBINDO) || (estado_q == DESCENDO)),
    .fim_o   (fim_viagem_s)
  );

  controle_elevador_temporizador #(.LARGURA(CNT_W)) u_temp_porta (
    .clk     (CLK),
    .rst     (RST),
    .carga_i (carga_porta_s),
    .valor_i (CARGA_PORTA),
    .en_i    (estado_q == PORTA_ABERTA),
    .fim_o   (fim_porta_s)
  );

  // Next state, floor, direction and timer loads.
  always_comb begin
    estado_d       = estado_q;
    andar_d        = andar_q;
    dir_d          = dir_q;
    carga_viagem_s = 1'b0;
    carga_porta_s  = 1'b0;
    ack_ev_s       = 1'b0;
    case (estado_q)
      PARADO: begin
        if (aqui_s) begin
          estado_d      = PORTA_ABERTA;
          carga_porta_s = 1'b1;
          ack_ev_s      = 1'b1;
        end else if (acima_s && abaixo_s) begin
          estado_d       = (dir_q == DIR_SOBE) ? SUBINDO : DESCENDO;
          carga_viagem_s = 1'b1;
        end else if (acima_s) begin
          estado_d       = SUBINDO;
          carga_viagem_s = 1'b1;
        end else if (abaixo_s) begin
          estado_d       = DESCENDO;
          carga_viagem_s = 1'b1;
        end else begin
          estado_d = PARADO;
        end
      end
      SUBINDO: begin
        if (fim_viagem_s) begin
          andar_d = andar_sobe_s;
          dir_d   = DIR_SOBE;
          if (sobe_aqui_s) begin
            estado_d      = PORTA_ABERTA;
            carga_porta_s = 1'b1;
            ack_ev_s      = 1'b1;
          end else if (sobe_acima_s) begin
            estado_d       = SUBINDO;
            carga_viagem_s = 1'b1;
          end else begin
            estado_d = PARADO;
          end
        end else begin
          estado_d = SUBINDO;
        end
      end
      DESCENDO: begin
        if (fim_viagem_s) begin
          andar_d = andar_desce_s;
          dir_d   = DIR_DESCE;
          if (desce_aqui_s) begin
            estado_d      = PORTA_ABERTA;
            carga_porta_s = 1'b1;
            ack_ev_s      = 1'b1;
          end else if (desce_abaixo_s) begin
            estado_d       = DESCENDO;
            carga_viagem_s = 1'b1;
          end else begin
            estado_d = PARADO;
          end
        end else begin
          estado_d = DESCENDO;
        end
      end
      PORTA_ABERTA: begin
        if (aqui_s && !ack_ativo_s) begin
          estado_d      = PORTA_ABERTA;
          carga_porta_s = 1'b1;
          ack_ev_s      = 1'b1;
        end else if (fim_porta_s) begin
          estado_d = PARADO;
        end else begin
          estado_d = PORTA_ABERTA;
        end
      end
      default: begin
        estado_d = PARADO;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    subir_d  = (estado_d == SUBINDO);
    descer_d = (estado_d == DESCENDO);
    porta_d  = (estado_d == PORTA_ABERTA);
    if (ack_ev_s) begin
      ack_d = decodifica_andar(andar_d);
    end else begin
      ack_d = 3'b000;
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      estado_q <= PARADO;
      andar_q  <= ANDAR_T;
      dir_q    <= DIR_SOBE;
      subir_q  <= 1'b0;
      descer_q <= 1'b0;
      porta_q  <= 1'b0;
      ack_q    <= 3'b000;
    end else begin
      estado_q <= estado_d;
      andar_q  <= andar_d;
      dir_q    <= dir_d;
      subir_q  <= subir_d;
      descer_q <= descer_d;
      porta_q  <= porta_d;
      ack_q    <= ack_d;
    end
  end

  assign A1     = andar_q[1];
  assign A0     = andar_q[0];
  assign SUBIR  = subir_q;
  assign DESCER = descer_q;
  assign PORTA  = porta_q;
  assign LT     = ack_q[0];
  assign LP     = ack_q[1];
  assign LS     = ack_q[2];

endmodule

// File: tb/tb_controle_elevador.sv
// Directed bench for controle_elevador (T_VIAGEM=8, T_PORTA=6) followed by
// a short random-call phase checking output exclusivity and ack placement.
module tb_controle_elevador;

  logic CLK = 1'b0;
  logic RST, CT, CP, CS;
  logic A1, A0, SUBIR, DESCER, PORTA, LT, LP, LS;

  int checks = 0;
  int errors = 0;
  int n_sub, n_des, n_porta, n_lt, n_lp, n_ls, n_a01;

  controle_elevador #(.T_VIAGEM(8), .T_PORTA(6)) dut (
    .CLK(CLK), .RST(RST), .CT(CT), .CP(CP), .CS(CS),
    .A1(A1), .A0(A0), .SUBIR(SUBIR), .DESCER(DESCER), .PORTA(PORTA),
    .LT(LT), .LP(LP), .LS(LS)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic zera;
    n_sub = 0; n_des = 0; n_porta = 0; n_lt = 0; n_lp = 0; n_ls = 0; n_a01 = 0;
  endtask

  task automatic amostra;
    if (SUBIR === 1'b1) n_sub++;
    if (DESCER === 1'b1) n_des++;
    if (PORTA === 1'b1) n_porta++;
    if (LT === 1'b1) n_lt++;
    if (LP === 1'b1) n_lp++;
    if (LS === 1'b1) n_ls++;
    if ({A1, A0} === 2'b01) n_a01++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      amostra;
    end
  endtask

  // Tick until the door closes (bounded); counters keep accumulating.
  task automatic fecha_porta;
    for (int i = 0; i < 40; i++) begin
      tick;
      amostra;
      if (PORTA !== 1'b1) break;
    end
  endtask

  task automatic saidas_zero(input string tag);
    chk2({tag, "_andar"}, {A1, A0}, 2'b00);
    chkb({tag, "_subir"}, SUBIR, 1'b0);
    chkb({tag, "_descer"}, DESCER, 1'b0);
    chkb({tag, "_porta"}, PORTA, 1'b0);
    chkb({tag, "_lt"}, LT, 1'b0);
    chkb({tag, "_lp"}, LP, 1'b0);
    chkb({tag, "_ls"}, LS, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; CT = 1'b0; CP = 1'b0; CS = 1'b0;
    zera;
    tick; tick;
    saidas_zero("reset");

    // Ground call at ground floor: door next cycle, one LT, 6 door cycles.
    RST = 1'b0; CT = 1'b1;
    tick;
    chkb("t028_porta", PORTA, 1'b1);
    chkb("t028_lt", LT, 1'b1);
    CT = 1'b0;
    zera; amostra; fecha_porta;
    chki("t028_porta_ciclos", n_porta, 6);
    chki("t028_lt_pulsos", n_lt, 1);
    chkb("t028_porta_fechada", PORTA, 1'b0);

    // Second-floor call from ground: 16 cycles up, passing floor 01.
    CS = 1'b1;
    zera; run(16);
    chki("t029_subir_ciclos", n_sub, 16);
    chki("t029_descer_ciclos", n_des, 0);
    chki("t029_ciclos_andar01", n_a01, 8);
    chki("t029_lp_pulsos", n_lp, 0);
    chki("t029_ls_cedo", n_ls, 0);
    tick;
    chkb("t029_porta", PORTA, 1'b1);
    chkb("t029_ls", LS, 1'b1);
    chkb("t029_subir_fim", SUBIR, 1'b0);
    chk2("t029_andar", {A1, A0}, 2'b10);
    CS = 1'b0;
    zera; amostra; fecha_porta;
    chki("t029_porta_ciclos", n_porta, 6);

    // Go down to floor 01 so the direction register holds "down".
    CP = 1'b1;
    zera; run(8);
    chki("t030p_descer_ciclos", n_des, 8);
    chki("t030p_subir_ciclos", n_sub, 0);
    tick;
    chkb("t030p_lp", LP, 1'b1);
    chk2("t030p_andar", {A1, A0}, 2'b01);
    CP = 1'b0;
    fecha_porta;

    // Calls on both sides with direction down: ground first, then second.
    CT = 1'b1; CS = 1'b1;
    tick;
    chkb("t030_descer_primeiro", DESCER, 1'b1);
    chkb("t030_subir_primeiro", SUBIR, 1'b0);
    run(7);
    tick;
    chkb("t030_lt", LT, 1'b1);
    chk2("t030_andar_t", {A1, A0}, 2'b00);
    CT = 1'b0;
    fecha_porta;
    tick;
    chkb("t030_subir", SUBIR, 1'b1);
    zera; run(15);
    chki("t030_subir_ciclos", n_sub, 15);
    chki("t030_lp_pulsos", n_lp, 0);
    tick;
    chkb("t030_ls", LS, 1'b1);
    chk2("t030_andar_s", {A1, A0}, 2'b10);
    CS = 1'b0;
    fecha_porta;

    // Door at 01 reopened by CP in its third cycle: 3 + 6 open cycles.
    CP = 1'b1;
    run(8);
    tick;
    chkb("t031_lp1", LP, 1'b1);
    chkb("t031_porta", PORTA, 1'b1);
    CP = 1'b0;
    zera; amostra;
    tick; amostra;
    tick; amostra;
    CP = 1'b1;
    tick; amostra;
    chkb("t031_lp2", LP, 1'b1);
    CP = 1'b0;
    fecha_porta;
    chki("t031_porta_ciclos", n_porta, 9);
    chki("t031_lp_pulsos", n_lp, 2);

    // Reset in the fourth cycle of travel; held CS is served from ground.
    CS = 1'b1;
    tick;
    chkb("t032_subir", SUBIR, 1'b1);
    tick; tick; tick;
    RST = 1'b1;
    tick;
    saidas_zero("t032_rst");
    RST = 1'b0;
    tick;
    chkb("t032_subir_reinicio", SUBIR, 1'b1);
    chk2("t032_andar_reinicio", {A1, A0}, 2'b00);
    zera; run(15);
    chki("t032_ls_cedo", n_ls, 0);
    tick;
    chkb("t032_ls", LS, 1'b1);
    chk2("t032_andar_s", {A1, A0}, 2'b10);
    CS = 1'b0;
    fecha_porta;

    // Random calls, cleared by their acknowledge as the call selector would.
    for (int i = 0; i < 400; i++) begin
      tick;
      chkb("x_motor_porta_exclusivos", ($countones({SUBIR, DESCER, PORTA}) <= 1), 1'b1);
      chkb("x_acks_exclusivos", ($countones({LT, LP, LS}) <= 1), 1'b1);
      chkb("x_andar_valido", ({A1, A0} != 2'b11), 1'b1);
      chkb("x_ack_com_porta", ((LT | LP | LS) ? PORTA : 1'b1), 1'b1);
      chkb("x_ack_andar",
           !((LT && ({A1, A0} != 2'b00)) || (LP && ({A1, A0} != 2'b01)) ||
             (LS && ({A1, A0} != 2'b10))), 1'b1);
      if (LT === 1'b1) CT = 1'b0;
      if (LP === 1'b1) CP = 1'b0;
      if (LS === 1'b1) CS = 1'b0;
      if ($urandom_range(0, 11) == 0) CT = 1'b1;
      if ($urandom_range(0, 11) == 0) CP = 1'b1;
      if ($urandom_range(0, 11) == 0) CS = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
